eprom_access_arbiter: RTL and testbench

//  Shares one asynchronous EPROM (M27256/M27512 class) between two read requesters,
//  e.g. the tile-layer and sprite fetch engines, on a single clock.

---
 rtl/eprom_access_arbiter.sv | 114 +++++++++++
 tb/tb_eprom_access_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/eprom_access_arbiter.sv
// Two-requester round-robin arbiter for one asynchronous EPROM.
// Runs the CE/OE access window, a wait-state count, data capture and a recovery gap.
module eprom_access_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_CYCLES = 10,
  parameter int HOLD_CYCLES = 1,
  parameter int USE_DV      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  output logic                  ack_a,
  input  logic                  req_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic                  ack_b,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rom_ce_n,
  output logic                  rom_oe_n,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  rom_dv
);

  localparam int MAX_CNT = (WAIT_CYCLES > HOLD_CYCLES) ? WAIT_CYCLES : HOLD_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RECOVER} state_t;

  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic                  last_b, last_b_d;  // 1: B was granted last
  logic                  win_b, win_b_d;
  logic                  enable_n, enable_n_d;
  logic                  ack_a_d, ack_b_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  sel_b;

  assign sel_b    = req_b & (~req_a | ~last_b);
  assign rom_ce_n = enable_n;
  assign rom_oe_n = enable_n;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    last_b_d   = last_b;
    win_b_d    = win_b;
    enable_n_d = enable_n;
    addr_d     = rom_addr;
    data_d     = data_out;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_a | req_b) begin
          win_b_d    = sel_b;
          last_b_d   = sel_b;
          addr_d     = sel_b ? addr_b : addr_a;
          enable_n_d = 1'b0;
          cnt_d      = CW'(WAIT_CYCLES);
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        // with data-valid handshake the count parks at 1 until rom_dv arrives
        if (cnt == CW'(1)) begin
          if ((USE_DV == 0) || rom_dv) state_d = CAPTURE;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      CAPTURE: begin
        data_d     = rom_data;
        ack_a_d    = ~win_b;
        ack_b_d    = win_b;
        enable_n_d = 1'b1;
        cnt_d      = CW'(HOLD_CYCLES);
        state_d    = RECOVER;
      end
      RECOVER: begin
        if (cnt == CW'(1)) state_d = IDLE;
        else               cnt_d   = cnt - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last_b   <= 1'b1;
      win_b    <= 1'b0;
      enable_n <= 1'b1;
      rom_addr <= '0;
      data_out <= '0;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      last_b   <= last_b_d;
      win_b    <= win_b_d;
      enable_n <= enable_n_d;
      rom_addr <= addr_d;
      data_out <= data_d;
      ack_a    <= ack_a_d;
      ack_b    <= ack_b_d;
    end
  end

endmodule

// File: tb/tb_eprom_access_arbiter.sv
// Bench for eprom_access_arbiter: three configurations checked every cycle against a
// timeline model (grant edge, ready edge, capture edge) plus directed literal checks.
module tb_eprom_access_arbiter;

  localparam int EXP_LAT [3] = '{11, 14, 2};
  localparam int RST_DLY [3] = '{5, 5, 1};

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] romf(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cfg%0d t=%0t got %0h want %0h", nm, g, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : blk
    localparam int W  = (g == 2) ? 1 : 10;
    localparam int H  = (g == 1) ? 2 : 1;
    localparam int DV = (g == 1) ? 1 : 0;

    logic        rst_n = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0, rom_dv = 1'b0;
    logic [15:0] addr_a = '0, addr_b = '0;
    logic        ack_a, ack_b, rom_ce_n, rom_oe_n;
    logic [7:0]  data_out, rom_data;
    logic [15:0] rom_addr;
    bit          done = 1'b0;

    assign rom_data = romf(rom_addr);

    eprom_access_arbiter #(
      .ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_CYCLES(W), .HOLD_CYCLES(H), .USE_DV(DV)
    ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .addr_a(addr_a), .ack_a(ack_a),
      .req_b(req_b), .addr_b(addr_b), .ack_b(ack_b),
      .data_out(data_out), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n),
      .rom_addr(rom_addr), .rom_data(rom_data), .rom_dv(rom_dv)
    );

    // Model: one transaction at a time, tracked by absolute edge numbers.
    bit          busy, last_b, win_b;
    logic [15:0] m_addr;
    logic [7:0]  m_data;
    logic        m_ack_a, m_ack_b, m_ce;
    int          e, gnt, ready, cap;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        busy = 0; last_b = 1; win_b = 0; m_addr = '0; m_data = '0;
        m_ack_a = 0; m_ack_b = 0; m_ce = 1; ready = -1; cap = -1;
      end else begin
        e++;
        m_ack_a = 0; m_ack_b = 0;
        if (!busy) begin
          if (req_a || req_b) begin
            win_b  = req_b && (!req_a || !last_b);
            last_b = win_b;
            m_addr = win_b ? addr_b : addr_a;
            m_ce   = 0; busy = 1; gnt = e; ready = -1; cap = -1;
          end
        end else if (ready < 0) begin
          if (e >= gnt + W && (DV == 0 || rom_dv)) ready = e;
        end else if (cap < 0) begin
          cap = e; m_data = romf(m_addr); m_ack_a = !win_b; m_ack_b = win_b; m_ce = 1;
        end else if (e >= cap + H) begin
          busy = 0;
        end
      end
    end

    always @(negedge clk) begin
      chk("ack_a", g, ack_a, m_ack_a);
      chk("ack_b", g, ack_b, m_ack_b);
      chk("ack_excl", g, ack_a & ack_b, 0);
      chk("ce_n", g, rom_ce_n, m_ce);
      chk("oe_n", g, rom_oe_n, m_ce);
      chk("rom_addr", g, rom_addr, m_addr);
      chk("data_out", g, data_out, m_data);
    end

    initial begin : drv
      int k;
      bit seen, ga, gb;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;

      // single A read of 0x1234; dv only arrives for the edge k+13
      @(posedge clk); #1 req_a = 1; addr_a = 16'h1234; k = cyc + 1; rom_dv = 0;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        rom_dv = (cyc >= k + 12);
        if (ack_a) seen = 1;
      end
      chk("latency_a", g, cyc - k, EXP_LAT[g]);
      chk("data_1234", g, data_out, 8'h83);
      chk("no_ack_b", g, ack_b, 0);
      req_a = 0; rom_dv = 1;
      repeat (4) @(posedge clk);

      // reset during the access, then a tie must go to A first
      #1 req_a = 1; addr_a = 16'h0F0F; k = cyc + 1;
      repeat (RST_DLY[g] + 1) @(posedge clk);
      #1 rst_n = 0;
      #1 chk("rst_ce_n", g, rom_ce_n, 1);
      chk("rst_oe_n", g, rom_oe_n, 1);
      chk("rst_ack", g, {ack_a, ack_b}, 0);
      req_a = 0;
      @(posedge clk); #1 rst_n = 1;
      req_a = 1; req_b = 1; addr_a = 16'h00AA; addr_b = 16'hBB00;
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge clk);
        if (ack_a || ack_b) seen = 1;
      end
      chk("tie_first_a", g, {ack_a, ack_b}, 2'b10);
      chk("tie_data", g, data_out, 8'h0F);
      req_a = 0;
      seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge clk);
        if (ack_b) seen = 1;
      end
      chk("tie_then_b", g, seen, 1);
      req_b = 0;

      // random traffic, including repeat reads and early request drops
      ga = 0; gb = 0;
      for (int i = 0; i < 1500; i++) begin
        @(negedge clk); ga = ack_a; gb = ack_b;
        @(posedge clk); #1;
        rom_dv = ($urandom_range(3) != 0);
        if (req_a) begin
          if (ga) req_a = ($urandom_range(3) == 0);
          else if ($urandom_range(15) == 0) req_a = 0;
        end else if ($urandom_range(2) == 0) begin
          req_a = 1; addr_a = 16'($urandom);
        end
        if (req_b) begin
          if (gb) req_b = ($urandom_range(3) == 0);
          else if ($urandom_range(15) == 0) req_b = 0;
        end else if ($urandom_range(2) == 0) begin
          req_b = 1; addr_b = 16'($urandom);
        end
      end
      req_a = 0; req_b = 0;
      repeat (30) @(posedge clk);
      done = 1;
    end
  end

  initial begin
    bit all_done;
    all_done = 0;
    for (int i = 0; i < 20000 && !all_done; i++) begin
      @(posedge clk);
      all_done = blk[0].done && blk[1].done && blk[2].done;
    end
    chk("finish_timeout", 0, all_done, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
